// File: rtl/alu_seq_pkg.sv
// Shared types for alu_seq: operation codes, flag bit positions and the
// sequencer state encoding.
package alu_seq_pkg;

    // Codes 0-7 match the legacy 3-bit ALU decode; 8-15 are the extensions.
    typedef enum logic [3:0] {
        CTRL_ADD = 4'd0,
        CTRL_SUB = 4'd1,
        CTRL_RLC = 4'd2,
        CTRL_RRC = 4'd3,
        CTRL_AND = 4'd4,
        CTRL_OR  = 4'd5,
        CTRL_XOR = 4'd6,
        CTRL_NOT = 4'd7,
        CTRL_ADC = 4'd8,
        CTRL_SBB = 4'd9,
        CTRL_RAL = 4'd10,
        CTRL_RAR = 4'd11,
        CTRL_CMP = 4'd12,
        CTRL_INC = 4'd13,
        CTRL_DEC = 4'd14,
        CTRL_MUL = 4'd15
    } ctrl_e;

    // Bit positions inside the 5-bit {S,Z,AC,P,CY} flag register.
    localparam int FLAG_S  = 4;
    localparam int FLAG_Z  = 3;
    localparam int FLAG_AC = 2;
    localparam int FLAG_P  = 1;
    localparam int FLAG_CY = 0;

    // IDLE accepts work; BUSY means a multiply is iterating.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
// done is asserted combinationally during the final iteration, and product
// then carries the value the accumulator is about to take, so the parent can
// register the result on the same edge the last iteration completes.
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;

    // One shift-add step; load operands on start.
    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;

        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
        done     = busy_q && (cnt_q == CW'(WIDTH - 1));
        product  = acc_next;

        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            acc_d    = '0;
            mplier_d = b;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    // Iteration registers; reset aborts any multiply in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered 8085-style ALU with flag register and optional iterative MUL.
// Handshake: an operation is taken on a rising edge where in_valid && in_ready;
// in_ready is high only in IDLE, and out_valid is a one-cycle pulse with no
// backpressure. Operands, ctrl and the carry-in (current CY) are all sampled
// on the accepting edge.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       ctrl,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             out_valid,
    output logic [4:0]       flags,
    output logic             dbg_state
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] out_hi_q, out_hi_d;
    logic             out_valid_q, out_valid_d;
    logic [4:0]       flags_q, flags_d;

    ctrl_e            op;
    logic             is_mul;
    logic             mul_start;
    logic             mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] mul_lo, mul_hi;
    logic [4:0]       mul_flags;

    logic             c_in;
    logic [WIDTH:0]   add_full, sub_full;
    logic [4:0]       add_nib, sub_nib;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] szp_src;
    logic             upd_szp;
    logic [4:0]       alu_flags;

    assign op        = ctrl_e'(ctrl);
    assign is_mul    = MUL_EN && (op == CTRL_MUL);
    assign in_ready  = (state_q == ST_IDLE);
    assign mul_start = in_valid && in_ready && is_mul;

    assign out       = out_q;
    assign out_hi    = out_hi_q;
    assign out_valid = out_valid_q;
    assign flags     = flags_q;
    assign dbg_state = state_q;

    generate
        if (MUL_EN) begin : g_mul
            alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .rst     (rst),
                .start   (mul_start),
                .a       (op1),
                .b       (op2),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    // Flags produced by a finishing multiply.
    always_comb begin
        mul_lo             = mul_product[WIDTH-1:0];
        mul_hi             = mul_product[2*WIDTH-1:WIDTH];
        mul_flags          = '0;
        mul_flags[FLAG_S]  = mul_lo[WIDTH-1];
        mul_flags[FLAG_Z]  = (mul_lo == '0);
        mul_flags[FLAG_AC] = 1'b0;
        mul_flags[FLAG_P]  = ~^mul_lo;
        mul_flags[FLAG_CY] = |mul_hi;
    end

    // Single-cycle datapath and flag logic for every non-MUL operation.
    always_comb begin
        c_in      = ((op == CTRL_ADC) || (op == CTRL_SBB)) ? flags_q[FLAG_CY] : 1'b0;
        add_full  = {1'b0, op1} + {1'b0, op2} + {{WIDTH{1'b0}}, c_in};
        add_nib   = {1'b0, op1[3:0]} + {1'b0, op2[3:0]} + {4'b0000, c_in};
        sub_full  = {1'b0, op1} - {1'b0, op2} - {{WIDTH{1'b0}}, c_in};
        sub_nib   = {1'b0, op1[3:0]} - {1'b0, op2[3:0]} - {4'b0000, c_in};
        alu_res   = op1;
        alu_flags = flags_q;
        upd_szp   = 1'b0;

        case (op)
            CTRL_ADD, CTRL_ADC: begin
                alu_res            = add_full[WIDTH-1:0];
                alu_flags[FLAG_CY] = add_full[WIDTH];
                alu_flags[FLAG_AC] = add_nib[4];
                upd_szp            = 1'b1;
            end
            CTRL_SUB, CTRL_SBB, CTRL_CMP: begin
                // CMP leaves op1 on the output but flags follow the difference.
                alu_res            = (op == CTRL_CMP) ? op1 : sub_full[WIDTH-1:0];
                alu_flags[FLAG_CY] = sub_full[WIDTH];
                alu_flags[FLAG_AC] = sub_nib[4];
                upd_szp            = 1'b1;
            end
            CTRL_RLC: begin
                alu_res            = {op1[WIDTH-2:0], op1[WIDTH-1]};
                alu_flags[FLAG_CY] = op1[WIDTH-1];
            end
            CTRL_RRC: begin
                alu_res            = {op1[0], op1[WIDTH-1:1]};
                alu_flags[FLAG_CY] = op1[0];
            end
            CTRL_RAL: begin
                alu_res            = {op1[WIDTH-2:0], flags_q[FLAG_CY]};
                alu_flags[FLAG_CY] = op1[WIDTH-1];
            end
            CTRL_RAR: begin
                alu_res            = {flags_q[FLAG_CY], op1[WIDTH-1:1]};
                alu_flags[FLAG_CY] = op1[0];
            end
            CTRL_AND: begin
                alu_res            = op1 & op2;
                alu_flags[FLAG_CY] = 1'b0;
                alu_flags[FLAG_AC] = 1'b1;
                upd_szp            = 1'b1;
            end
            CTRL_OR: begin
                alu_res            = op1 | op2;
                alu_flags[FLAG_CY] = 1'b0;
                alu_flags[FLAG_AC] = 1'b0;
                upd_szp            = 1'b1;
            end
            CTRL_XOR: begin
                alu_res            = op1 ^ op2;
                alu_flags[FLAG_CY] = 1'b0;
                alu_flags[FLAG_AC] = 1'b0;
                upd_szp            = 1'b1;
            end
            CTRL_INC: begin
                alu_res            = op1 + ONE;
                alu_flags[FLAG_AC] = &op1[3:0];
                upd_szp            = 1'b1;
            end
            CTRL_DEC: begin
                alu_res            = op1 - ONE;
                alu_flags[FLAG_AC] = ~|op1[3:0];
                upd_szp            = 1'b1;
            end
            // NOT, and MUL when the multiplier is not built.
            default: begin
                alu_res = ~op1;
            end
        endcase

        szp_src = (op == CTRL_CMP) ? sub_full[WIDTH-1:0] : alu_res;
        if (upd_szp) begin
            alu_flags[FLAG_S] = szp_src[WIDTH-1];
            alu_flags[FLAG_Z] = (szp_src == '0);
            alu_flags[FLAG_P] = ~^szp_src;
        end
    end

    // Sequencer: next state and result/flag register updates.
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_hi_d    = out_hi_q;
        flags_d     = flags_q;
        out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_mul) begin
                        state_d = ST_BUSY;
                    end else begin
                        out_d       = alu_res;
                        out_hi_d    = '0;
                        flags_d     = alu_flags;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    state_d     = ST_IDLE;
                    out_d       = mul_lo;
                    out_hi_d    = mul_hi;
                    flags_d     = mul_flags;
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Architectural registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_q       <= '0;
            out_hi_q    <= '0;
            out_valid_q <= 1'b0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_hi_q    <= out_hi_d;
            out_valid_q <= out_valid_d;
            flags_q     <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=8): behavioural reference model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [3:0]   ctrl;
    logic [W-1:0] out;
    logic [W-1:0] out_hi;
    logic         out_valid;
    logic [4:0]   flags;
    logic         dbg_state;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .ctrl      (ctrl),
        .out       (out),
        .out_hi    (out_hi),
        .out_valid (out_valid),
        .flags     (flags),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         m_out    = 0;
    int         m_hi     = 0;
    logic [4:0] m_flags  = 5'd0;
    logic       m_valid  = 1'b0;
    int         m_cnt    = 0;
    int         p_out    = 0;
    int         p_hi     = 0;
    logic [4:0] p_flags  = 5'd0;

    function automatic int popcount(input int v);
        int n = 0;
        for (int i = 0; i < W; i++) n += (v >> i) & 1;
        return n;
    endfunction

    // Result of one operation from the architectural rules, in integer arithmetic.
    function automatic void model_op(input int c, input int a, input int b,
                                     input logic [4:0] f, output int r,
                                     output int hi, output logic [4:0] nf);
        int   m   = (1 << W) - 1;
        int   cy  = int'(f[0]);
        int   s   = 0;
        int   cin = 0;
        int   v;
        int   p;
        bit   szp = 1'b1;
        logic fs  = f[4];
        logic fz  = f[3];
        logic fac = f[2];
        logic fp  = f[1];
        logic fcy = f[0];
        r  = a;
        hi = 0;
        case (c)
            0, 8: begin
                cin = (c == 8) ? cy : 0;
                s   = a + b + cin;
                r   = s & m;
                fcy = (s > m);
                fac = ((a & 15) + (b & 15) + cin) > 15;
            end
            1, 9, 12: begin
                cin = (c == 9) ? cy : 0;
                s   = a - b - cin;
                r   = (c == 12) ? a : (s & m);
                fcy = (s < 0);
                fac = ((a & 15) - (b & 15) - cin) < 0;
            end
            2:  begin r = ((a << 1) | (a >> (W - 1))) & m; fcy = (a >> (W - 1)) & 1; szp = 0; end
            3:  begin r = (a >> 1) | ((a & 1) << (W - 1));  fcy = a & 1;            szp = 0; end
            4:  begin r = a & b; fcy = 0; fac = 1; end
            5:  begin r = a | b; fcy = 0; fac = 0; end
            6:  begin r = a ^ b; fcy = 0; fac = 0; end
            7:  begin r = (~a) & m; szp = 0; end
            10: begin r = ((a << 1) | cy) & m;          fcy = (a >> (W - 1)) & 1; szp = 0; end
            11: begin r = (a >> 1) | (cy << (W - 1));    fcy = a & 1;            szp = 0; end
            13: begin r = (a + 1) & m; fac = ((a & 15) + 1) > 15; end
            14: begin r = (a - 1) & m; fac = ((a & 15) - 1) < 0; end
            default: begin
                p   = a * b;
                r   = p & m;
                hi  = (p >> W) & m;
                fcy = (hi != 0);
                fac = 0;
            end
        endcase
        if (szp) begin
            v  = (c == 12) ? (s & m) : r;
            fs = (v >> (W - 1)) & 1;
            fz = (v == 0);
            fp = (popcount(v) % 2) == 0;
        end
        nf = {fs, fz, fac, fp, fcy};
    endfunction

    // Model advances on each rising edge using the inputs held since the falling edge.
    always @(posedge clk) begin
        int         r;
        int         h;
        logic [4:0] nf;
        if (rst) begin
            m_out = 0; m_hi = 0; m_flags = 5'd0; m_valid = 1'b0; m_cnt = 0;
        end else begin
            m_valid = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_out = p_out; m_hi = p_hi; m_flags = p_flags; m_valid = 1'b1;
                end
            end else if (in_valid) begin
                model_op(int'(ctrl), int'(op1), int'(op2), m_flags, r, h, nf);
                if (ctrl == 4'd15) begin
                    p_out = r; p_hi = h; p_flags = nf; m_cnt = W;
                end else begin
                    m_out = r; m_hi = h; m_flags = nf; m_valid = 1'b1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, just after the active edge.
    always @(posedge clk) begin
        #1;
        chk("model_out",       32'(out),       32'(m_out));
        chk("model_out_hi",    32'(out_hi),    32'(m_hi));
        chk("model_flags",     32'(flags),     32'(m_flags));
        chk("model_out_valid", 32'(out_valid), 32'(m_valid));
        chk("model_in_ready",  32'(in_ready),  32'(m_cnt == 0));
        chk("model_busy",      32'(dbg_state), 32'(m_cnt != 0));
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [3:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic v);
        @(negedge clk);
        ctrl = c; op1 = a; op2 = b; in_valid = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(4'd0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Directed table of mixed non-MUL operations, issued back to back.
    logic [3:0]   t_ctrl[12] = '{4'd4, 4'd6, 4'd12, 4'd13, 4'd14, 4'd0,
                                 4'd8, 4'd2, 4'd3, 4'd5, 4'd12, 4'd9};
    logic [W-1:0] t_a[12]    = '{8'hF0, 8'hAA, 8'h20, 8'hFF, 8'h00, 8'hFF,
                                 8'h0F, 8'h81, 8'h01, 8'h00, 8'h10, 8'h00};
    logic [W-1:0] t_b[12]    = '{8'h3C, 8'h55, 8'h20, 8'h00, 8'h00, 8'h01,
                                 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00};

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; in_valid = 1'b0; ctrl = 4'd0; op1 = '0; op2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out",       32'(out),       32'h0);
        chk("reset_out_hi",    32'(out_hi),    32'h0);
        chk("reset_flags",     32'(flags),     32'h0);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_in_ready",  32'(in_ready),  32'h1);
        @(negedge clk);
        rst = 1'b0;

        // ADD 0x3A+0xC6 -> 0x00, S0 Z1 AC1 P1 CY1
        drive(4'd0, 8'h3A, 8'hC6, 1'b1);
        after_edge();
        chk("add_out",   32'(out),       32'h00);
        chk("add_flags", 32'(flags),     32'h0F);
        chk("add_valid", 32'(out_valid), 32'h1);
        idle(1);
        after_edge();
        chk("add_valid_drop", 32'(out_valid), 32'h0);
        chk("add_out_hold",   32'(out),       32'h00);

        // NOT with CY=1 set: flags untouched
        drive(4'd7, 8'h5A, 8'h00, 1'b1);
        after_edge();
        chk("not_out",   32'(out),   32'hA5);
        chk("not_flags", 32'(flags), 32'h0F);

        // SUB then SBB back to back
        drive(4'd1, 8'h05, 8'h07, 1'b1);
        after_edge();
        chk("sub_out",   32'(out),   32'hFE);
        chk("sub_flags", 32'(flags), 32'h15);
        drive(4'd9, 8'h10, 8'h01, 1'b1);
        after_edge();
        chk("sbb_out",   32'(out),   32'h0E);
        chk("sbb_flags", 32'(flags), 32'h04);

        // RAL through CY=0, then RAR through CY=1
        drive(4'd10, 8'h80, 8'h00, 1'b1);
        after_edge();
        chk("ral_out",   32'(out),   32'h00);
        chk("ral_flags", 32'(flags), 32'h05);
        drive(4'd11, 8'h00, 8'h00, 1'b1);
        after_edge();
        chk("rar_out",   32'(out),   32'h80);
        chk("rar_flags", 32'(flags), 32'h04);

        // Directed table and a burst of random non-MUL operations
        for (int i = 0; i < 12; i++) drive(t_ctrl[i], t_a[i], t_b[i], 1'b1);
        for (int i = 0; i < 20; i++)
            drive(4'($urandom_range(0, 14)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        idle(1);

        // MUL 0xFF*0xFF with in_valid held during BUSY
        drive(4'd15, 8'hFF, 8'hFF, 1'b1);
        after_edge();
        chk("mul_ready_0", 32'(in_ready),  32'h0);
        chk("mul_valid_0", 32'(out_valid), 32'h0);
        for (int i = 1; i < W; i++) begin
            drive(4'd0, 8'h01, 8'h01, 1'b1);
            after_edge();
            chk("mul_ready_busy", 32'(in_ready),  32'h0);
            chk("mul_valid_busy", 32'(out_valid), 32'h0);
        end
        drive(4'd0, 8'h01, 8'h01, 1'b1);
        after_edge();
        chk("mul_valid",  32'(out_valid), 32'h1);
        chk("mul_out",    32'(out),       32'h01);
        chk("mul_out_hi", 32'(out_hi),    32'hFE);
        chk("mul_flags",  32'(flags),     32'h01);
        chk("mul_ready",  32'(in_ready),  32'h1);
        idle(2);

        // Random-operand multiplies followed by a plain op clearing out_hi
        for (int i = 0; i < 3; i++) begin
            drive(4'd15, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
            idle(W + 1);
        end
        drive(4'd15, 8'h00, 8'h37, 1'b1);
        idle(W + 1);
        drive(4'd5, 8'h12, 8'h00, 1'b1);
        idle(1);

        // Reset four cycles into a MUL aborts it
        drive(4'd0, 8'h3A, 8'hC6, 1'b1);
        drive(4'd15, 8'hFF, 8'hFF, 1'b1);
        idle(3);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        after_edge();
        chk("abort_out",       32'(out),       32'h0);
        chk("abort_out_hi",    32'(out_hi),    32'h0);
        chk("abort_flags",     32'(flags),     32'h0);
        chk("abort_out_valid", 32'(out_valid), 32'h0);
        chk("abort_in_ready",  32'(in_ready),  32'h1);
        @(negedge clk);
        rst = 1'b0;
        idle(W + 2);
        drive(4'd0, 8'h01, 8'h01, 1'b1);
        after_edge();
        chk("post_abort_add", 32'(out), 32'h02);
        idle(2);
        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
